// File: rtl/pg68k_bus_pkg.sv
// Shared 030 asynchronous bus encodings: SIZ codes, DSACK port-size codes and
// bus-master state encodings, common to the master, dramctl and bus monitors.
package pg68k_bus_pkg;

  // SIZ1:SIZ0 encodes bytes remaining in the operand
  localparam logic [1:0] SIZ_4 = 2'b00;
  localparam logic [1:0] SIZ_1 = 2'b01;
  localparam logic [1:0] SIZ_2 = 2'b10;
  localparam logic [1:0] SIZ_3 = 2'b11;

  // nDSACK1:nDSACK0 as sampled (active-low), giving the responder port width
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  typedef logic [2:0] bus_state_t;

  localparam bus_state_t ST_IDLE  = 3'd0;
  localparam bus_state_t ST_S1    = 3'd1;
  localparam bus_state_t ST_S2    = 3'd2;
  localparam bus_state_t ST_S3    = 3'd3;
  localparam bus_state_t ST_WAIT  = 3'd4;
  localparam bus_state_t ST_LATCH = 3'd5;
  localparam bus_state_t ST_END   = 3'd6;

  // Byte count for a SIZ code (00 means a full long word)
  function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
    return (siz == SIZ_4) ? 3'd4 : {1'b0, siz};
  endfunction

endpackage

// File: rtl/m68k_bus_sizer.sv
// Dynamic bus sizing datapath: bytes moved per cycle, read lane extraction
// and write lane replication, all purely combinational.
module m68k_bus_sizer
  import pg68k_bus_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  rem,
  input  logic [1:0]  port,
  input  logic [31:0] d_in,
  input  logic [31:0] wbuf,
  output logic [2:0]  k,
  output logic [31:0] rd_bytes,
  output logic [31:0] wr_lanes
);

  logic [2:0] k_port;
  logic [1:0] start;
  logic [7:0] b0, b1, b2, b3;

  assign b0 = wbuf[31:24];
  assign b1 = wbuf[23:16];
  assign b2 = wbuf[15:8];
  assign b3 = wbuf[7:0];

  // Port width and alignment decide how many bytes this cycle moves and which lane holds the first one
  always_comb begin
    k_port = 3'd1;
    start  = 2'd0;
    case (port)
      DSACK_32: begin
        k_port = 3'd4 - {1'b0, addr_lo};
        start  = addr_lo;
      end
      DSACK_16: begin
        k_port = 3'd2 - {2'b00, addr_lo[0]};
        start  = {1'b0, addr_lo[0]};
      end
      default: begin
        k_port = 3'd1;
        start  = 2'd0;
      end
    endcase
    k = (k_port < rem) ? k_port : rem;
    // Move the first valid lane to the top, then right-align k bytes
    rd_bytes = (d_in << {start, 3'b000}) >> {3'd4 - k, 3'b000};
  end

  // Replicate the next operand bytes so any port width finds them on its own lanes
  always_comb begin
    case (addr_lo)
      2'b00:   wr_lanes = {b0, b1, b2, b3};
      2'b01:   wr_lanes = {b0, b0, b1, b2};
      2'b10:   wr_lanes = {b0, b1, b0, b1};
      default: wr_lanes = {b0, b0, b1, b0};
    endcase
  end

endmodule

// File: rtl/m68k_bus_master.sv
// 030 asynchronous bus initiator: one 1-4 byte operand becomes one or more
// nAS/nDS cycles with dynamic bus sizing, terminated by nDSACK or nBERR.
//
// state | meaning
// IDLE  | waiting for REQ
// S1    | address, SIZ, direction (and write data) driven
// S2    | nAS asserted (and nDS for reads), timeout counter cleared
// S3    | writes only: nDS asserted
// WAIT  | waiting for nDSACK / nBERR / timeout
// LATCH | capture read bytes, record bytes moved
// END   | strobes negated, wait for responder release, then finish or next cycle
module m68k_bus_master
  import pg68k_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic [31:0] REQ_ADDR,
  input  logic        REQ_RnW,
  input  logic [1:0]  REQ_SIZE,
  input  logic [31:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic [31:0] ADDR,
  output logic        SIZ1,
  output logic        SIZ0,
  output logic        RnW,
  output logic        nAS,
  output logic        nDS,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  input  logic [31:0] D_IN,
  input  logic        nDSACK1,
  input  logic        nDSACK0,
  input  logic        nBERR
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_t       state;
  logic [31:0]      addr_r;
  logic [2:0]       rem_r;
  logic [31:0]      wbuf;
  logic [31:0]      rbuf;
  logic             rnw_r;
  logic             abort_r;
  logic [1:0]       port_r;
  logic [2:0]       k_r;
  logic [CNT_W-1:0] cnt;

  logic [2:0]  rem_in;
  logic [2:0]  k;
  logic [31:0] rd_bytes;
  logic [31:0] wr_lanes;
  logic [1:0]  dsack;

  assign rem_in = siz_bytes(REQ_SIZE);
  assign dsack  = {nDSACK1, nDSACK0};

  m68k_bus_sizer u_sizer (
    .addr_lo  (addr_r[1:0]),
    .rem      (rem_r),
    .port     (port_r),
    .d_in     (D_IN),
    .wbuf     (wbuf),
    .k        (k),
    .rd_bytes (rd_bytes),
    .wr_lanes (wr_lanes)
  );

  // Bus pins decode from state; addr/rem/wbuf only advance in END so they stay stable under the strobes
  always_comb begin
    ADDR  = addr_r;
    SIZ1  = rem_r[1];
    SIZ0  = rem_r[0];
    RnW   = rnw_r || (state == ST_IDLE);
    nAS   = !(state inside {ST_S2, ST_S3, ST_WAIT, ST_LATCH});
    nDS   = !((state inside {ST_S3, ST_WAIT, ST_LATCH}) || (state == ST_S2 && rnw_r));
    D_OE  = !rnw_r && (state inside {ST_S1, ST_S2, ST_S3, ST_WAIT, ST_LATCH});
    D_OUT = D_OE ? wr_lanes : 32'h0;
  end

  // Bus cycle sequencer, operand bookkeeping and completion handshake
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      addr_r  <= '0;
      rem_r   <= '0;
      wbuf    <= '0;
      rbuf    <= '0;
      rnw_r   <= 1'b1;
      abort_r <= 1'b0;
      port_r  <= DSACK_32;
      k_r     <= '0;
      cnt     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            addr_r  <= REQ_ADDR;
            rem_r   <= rem_in;
            wbuf    <= REQ_WDATA << {3'd4 - rem_in, 3'b000};
            rbuf    <= '0;
            rnw_r   <= REQ_RnW;
            abort_r <= 1'b0;
            BUSY    <= 1'b1;
            state   <= ST_S1;
          end
        end
        ST_S1: state <= ST_S2;
        ST_S2: begin
          cnt   <= '0;
          state <= rnw_r ? ST_WAIT : ST_S3;
        end
        ST_S3: state <= ST_WAIT;
        ST_WAIT: begin
          if (!nBERR) begin
            abort_r <= 1'b1;
            state   <= ST_END;
          end else if (cnt == TO_LAST) begin
            abort_r <= 1'b1;
            state   <= ST_END;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (dsack != DSACK_NONE) begin
              port_r <= dsack;
              state  <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          k_r <= k;
          if (rnw_r) rbuf <= (rbuf << {k, 3'b000}) | rd_bytes;
          state <= ST_END;
        end
        ST_END: begin
          if (dsack == DSACK_NONE && nBERR) begin
            if (abort_r || rem_r == k_r) begin
              DONE  <= 1'b1;
              ERR   <= abort_r;
              BUSY  <= 1'b0;
              if (rnw_r) RDATA <= rbuf;
              state <= ST_IDLE;
            end else begin
              addr_r <= addr_r + {29'b0, k_r};
              rem_r  <= rem_r - k_r;
              wbuf   <= wbuf << {k_r, 3'b000};
              state  <= ST_S1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master with a behavioural sized-port responder.
module tb_m68k_bus_master;

  localparam int TO = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic [31:0] REQ_ADDR = '0;
  logic        REQ_RnW = 1'b1;
  logic [1:0]  REQ_SIZE = 2'b00;
  logic [31:0] REQ_WDATA = '0;
  logic        BUSY, DONE, ERR;
  logic [31:0] RDATA, ADDR, D_OUT;
  logic        SIZ1, SIZ0, RnW, nAS, nDS, D_OE;
  logic [31:0] D_IN = '0;
  logic        nDSACK1 = 1'b1;
  logic        nDSACK0 = 1'b1;
  logic        nBERR = 1'b1;

  m68k_bus_master #(.TIMEOUT_CYCLES(TO), .CNT_W(11)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_RnW(REQ_RnW),
    .REQ_SIZE(REQ_SIZE), .REQ_WDATA(REQ_WDATA), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .RDATA(RDATA), .ADDR(ADDR), .SIZ1(SIZ1), .SIZ0(SIZ0),
    .RnW(RnW), .nAS(nAS), .nDS(nDS), .D_OUT(D_OUT), .D_OE(D_OE),
    .D_IN(D_IN), .nDSACK1(nDSACK1), .nDSACK0(nDSACK0), .nBERR(nBERR)
  );

  always #20 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  // Responder configuration (written by the stimulus) and cycle log (written by the responder)
  logic [1:0]  port_code = 2'b00;
  logic [1:0]  berr_code = 2'b11;
  bit          no_resp = 1'b0;
  int          resp_wait = 0;
  int          berr_at = -1;
  int          op_base = 0;
  logic [31:0] rq [4];
  int          ncyc = 0;
  int          wcnt = 0;
  bit          acked = 1'b0;
  logic [31:0] log_addr [64];
  logic [1:0]  log_siz [64];
  logic [31:0] log_dout [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Responder: terminates each strobed cycle after resp_wait clocks, releases when nAS rises
  always @(negedge CLK) begin
    if (nAS) begin
      nDSACK1 = 1'b1;
      nDSACK0 = 1'b1;
      nBERR = 1'b1;
      acked = 1'b0;
      wcnt = 0;
    end else if (!nDS && !acked && !no_resp) begin
      if (wcnt < resp_wait) wcnt++;
      else begin
        if (ncyc < 64) begin
          log_addr[ncyc] = ADDR;
          log_siz[ncyc] = {SIZ1, SIZ0};
          log_dout[ncyc] = D_OUT;
        end
        D_IN = (ncyc - op_base < 4) ? rq[ncyc - op_base] : 32'h0;
        if (ncyc - op_base == berr_at) begin
          nBERR = 1'b0;
          {nDSACK1, nDSACK0} = berr_code;
        end else begin
          {nDSACK1, nDSACK0} = port_code;
        end
        ncyc++;
        acked = 1'b1;
      end
    end
  end

  // Issues one operand at a negedge and returns at the negedge where DONE is seen
  task automatic do_op(input logic [31:0] a, input logic rnw, input logic [1:0] sz,
                       input logic [31:0] wd, input bit hold,
                       output logic [31:0] rd, output logic er, output int cyc);
    int clocks;
    bit got;
    op_base = ncyc;
    REQ = 1'b1; REQ_ADDR = a; REQ_RnW = rnw; REQ_SIZE = sz; REQ_WDATA = wd;
    @(negedge CLK);
    if (!hold) begin
      REQ = 1'b0;
      REQ_ADDR = 32'hFFFF_FFF0;
    end
    chk("busy", BUSY, 1);
    clocks = 0;
    got = 1'b0;
    while (!got && clocks < 3000) begin
      if (DONE) got = 1'b1;
      else begin
        @(negedge CLK);
        clocks++;
      end
    end
    REQ = 1'b0;
    if (!got) chk("done_seen", 0, 1);
    rd = RDATA;
    er = ERR;
    cyc = ncyc - op_base;
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;
  int          b;
  int          n;
  bit          seen;

  initial begin
    rq[0] = '0; rq[1] = '0; rq[2] = '0; rq[3] = '0;
    repeat (3) @(negedge CLK);
    chk("rst_strobes", {nAS, nDS, RnW, D_OE}, 4'b1110);
    chk("rst_addr", ADDR, 0);
    chk("rst_siz", {SIZ1, SIZ0}, 0);
    chk("rst_dout", D_OUT, 0);
    chk("rst_flags", {BUSY, DONE, ERR}, 0);
    chk("rst_rdata", RDATA, 0);
    RST = 1'b0;
    @(negedge CLK);

    // long read from a 32-bit port, REQ held high throughout (must be ignored while busy)
    port_code = 2'b00; rq[0] = 32'hDEAD_BEEF;
    b = ncyc;
    do_op(32'h100, 1'b1, 2'b00, 0, 1'b1, rd, er, cyc);
    chk("lr_rdata", rd, 32'hDEAD_BEEF);
    chk("lr_err", er, 0);
    chk("lr_cycles", cyc, 1);
    chk("lr_addr", log_addr[b], 32'h100);
    chk("lr_siz", log_siz[b], 2'b00);
    @(negedge CLK);
    chk("lr_busy_after", BUSY, 0);
    chk("lr_no_retrigger", ncyc - b, 1);

    // long write to a 16-bit port at an odd address: three cycles
    port_code = 2'b01;
    b = ncyc;
    do_op(32'h201, 1'b0, 2'b00, 32'h1122_3344, 1'b0, rd, er, cyc);
    chk("lw_err", er, 0);
    chk("lw_cycles", cyc, 3);
    chk("lw_a0", log_addr[b], 32'h201);
    chk("lw_s0", log_siz[b], 2'b00);
    chk("lw_d0", log_dout[b], 32'h1111_2233);
    chk("lw_a1", log_addr[b+1], 32'h202);
    chk("lw_s1", log_siz[b+1], 2'b11);
    chk("lw_d1", log_dout[b+1], 32'h2233_2233);
    chk("lw_a2", log_addr[b+2], 32'h204);
    chk("lw_s2", log_siz[b+2], 2'b01);
    chk("lw_d2", log_dout[b+2], 32'h4400_0000);

    // word read at 0x3 from an 8-bit port with wait states; only lane 0 is taken
    port_code = 2'b10; resp_wait = 2;
    rq[0] = 32'hAB12_3456; rq[1] = 32'hCD78_9ABC;
    b = ncyc;
    do_op(32'h3, 1'b1, 2'b10, 0, 1'b0, rd, er, cyc);
    chk("wr8_rdata", rd, 32'h0000_ABCD);
    chk("wr8_cycles", cyc, 2);
    chk("wr8_a0", log_addr[b], 32'h3);
    chk("wr8_s0", log_siz[b], 2'b10);
    chk("wr8_a1", log_addr[b+1], 32'h4);
    chk("wr8_s1", log_siz[b+1], 2'b01);
    resp_wait = 0;

    // 3-byte read at 0x1 from a 32-bit port: lanes 1..3
    port_code = 2'b00; rq[0] = 32'h11AA_BBCC;
    do_op(32'h1, 1'b1, 2'b11, 0, 1'b0, rd, er, cyc);
    chk("r3_rdata", rd, 32'h00AA_BBCC);
    chk("r3_cycles", cyc, 1);

    // byte write at 0x12 to an 8-bit port: replication puts the byte on lanes 0 and 2
    port_code = 2'b10;
    b = ncyc;
    do_op(32'h12, 1'b0, 2'b01, 32'h0000_005A, 1'b0, rd, er, cyc);
    chk("bw_dout", log_dout[b], 32'h5A00_5A00);
    chk("bw_siz", log_siz[b], 2'b01);
    chk("bw_cycles", cyc, 1);

    // split long write, bus error together with nDSACK=00 on the second cycle
    port_code = 2'b01; berr_at = 1; berr_code = 2'b00;
    do_op(32'h201, 1'b0, 2'b00, 32'h1122_3344, 1'b0, rd, er, cyc);
    chk("be_err", er, 1);
    chk("be_cycles", cyc, 2);
    repeat (8) @(negedge CLK);
    chk("be_no_third", ncyc - op_base, 2);
    chk("be_idle", {BUSY, nAS}, 2'b01);

    // bus error alone on a long read
    port_code = 2'b00; berr_at = 0; berr_code = 2'b11;
    do_op(32'h500, 1'b1, 2'b00, 0, 1'b0, rd, er, cyc);
    chk("ber_err", er, 1);
    chk("ber_rdata", rd, 0);
    berr_at = -1;

    // no termination: END after TIMEOUT_CYCLES clocks in WAIT, DONE+ERR on the next clock
    no_resp = 1'b1;
    REQ = 1'b1; REQ_ADDR = 32'h400; REQ_RnW = 1'b1; REQ_SIZE = 2'b00;
    @(negedge CLK);
    REQ = 1'b0;
    n = 0;
    while (nAS && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("to_as_low", nAS, 0);
    n = 0;
    while (!nAS && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    // one S2 clock plus TIMEOUT_CYCLES clocks in WAIT with nAS low
    chk("to_as_len", n, TO + 1);
    chk("to_done_early", DONE, 0);
    @(negedge CLK);
    chk("to_done_err", {DONE, ERR}, 2'b11);

    // reset while waiting for termination
    REQ = 1'b1; REQ_ADDR = 32'h600; REQ_RnW = 1'b1; REQ_SIZE = 2'b00;
    @(negedge CLK);
    REQ = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rw_in_wait", nAS, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("rw_strobes", {nAS, nDS, RnW, D_OE}, 4'b1110);
    chk("rw_addr", ADDR, 0);
    chk("rw_flags", {BUSY, DONE, ERR}, 0);
    seen = 1'b0;
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    chk("rw_no_done", seen, 0);
    no_resp = 1'b0;

    // back-to-back reads: second REQ issued in the cycle DONE is seen
    port_code = 2'b00; rq[0] = 32'h0102_0304;
    do_op(32'h700, 1'b1, 2'b00, 0, 1'b0, rd, er, cyc);
    chk("bb1_rdata", rd, 32'h0102_0304);
    rq[0] = 32'h5566_7788;
    do_op(32'h702, 1'b1, 2'b10, 0, 1'b0, rd, er, cyc);
    chk("bb2_rdata", rd, 32'h0000_7788);
    chk("bb2_err", er, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
